seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//  Time-multiplexed driver for DIGITS common-anode 7-segment digits sharing one segment bus.
//  Holds a frame-synchronous display register loaded from a shadow register and decodes
//  each 4-bit nibble to full hex 0-F. Scans one digit per prescaler tick.
//  Sits between the datapath and the board display pins; replaces per-digit combinational decoders.
// PARAMETERS
//  DIGITS     4      number of digits scanned (1..8)
//  PRESCALE   50000  clk cycles per digit slot (>=2)
//  BLINK_DIV  64     frames per blink half-period (used only with SEG7_BLINK_EN)
// PORTS
//  clk        in   1          system clock, rising edge
//  reset      in   1          asynchronous, active-high reset
//  load       in   1          1-cycle request: capture data_in/dp_in/blank_in into shadow
//  data_in    in   4*DIGITS   nibble k = data_in[4k+3:4k] -> digit k (digit 0 rightmost)
//  dp_in      in   DIGITS     decimal point per digit, 1 = lit
//  blank_in   in   DIGITS     1 = digit k dark (segments and dp off)
//  blink_in   in   DIGITS     1 = digit k blinks (port exists only with SEG7_BLINK_EN)
//  pending    out  1          shadow holds data not yet committed to display register
//  seg        out  7          active-low segments, seg[6:0] = {A,B,C,D,E,F,G}
//  dp         out  1          active-low decimal point
//  an         out  DIGITS     active-low digit enables, one-hot-low while scanning
// BEHAVIOUR
//  - Reset (async): prescaler=0, index=0, shadow/display data=0, display blank mask all 1,
//    pending=0, seg=7'h7F, dp=1, an=all 1. an stays all 1 until first tick.
//  - Prescaler counts 0..PRESCALE-1; tick = 1 cycle at PRESCALE-1, then wraps to 0.
//  - On tick: index <= (index==DIGITS-1) ? 0 : index+1. Wrap = frame boundary.
//  - Outputs registered: seg/dp/an reflect new index one clk after tick; an[index]=0, others 1.
//  - load=1: shadow <= inputs, pending <= 1. load while pending overwrites shadow (last wins).
//  - Commit: on frame-boundary tick with pending=1 (or load in same cycle), display <= shadow
//    (same-cycle load value used), pending <= 0. New content first shown on digit 0 slot.
//    No mid-frame tearing: a frame always shows one consistent register set.
//  - Decode (active-low, {A..G}): 0=0000001 1=1001111 2=0010010 3=0000110 4=1001100
//    5=0100100 6=0100000 7=0001111 8=0000000 9=0000100 A=0001000 b=1100000
//    C=0110001 d=1000010 E=0110000 F=0111000.
//  - Blanked digit: seg=7'h7F, dp=1; an still strobes (constant brightness timing).
//  - dp = ~dp_in bit of display register unless blanked.
//  - reset mid-frame: all state returns to reset values immediately; pending load lost.
// CONFIGURATION
//  SEG7_BLINK_EN defined: blink_in added to shadow/display sets; frame counter counts
//    BLINK_DIV frames, toggling blink phase (reset phase=on). Phase off -> digits with
//    blink bit set are blanked as above. Phase toggles on frame-boundary tick.
//  SEG7_BLINK_EN undefined: no blink_in port, no frame counter; behaviour as above only.
// TESTING (DIGITS=4, PRESCALE=4, BLINK_DIV=2)
//  1 reset asserted mid-scan -> seg=7'h7F, dp=1, an=4'b1111, pending=0 same cycle; an=4'b1110
//    one clk after first tick post-release.
//  2 load data_in=16'h8A31, dp_in=4'b0100, blank_in=0 -> pending=1 until frame wrap; next frame
//    digit0 seg=1001111, digit1 seg=0000110, digit2 seg=0001000 dp=0, digit3 seg=0000000.
//  3 two loads mid-frame (16'h1111 then 16'h2222) -> only 2222 ever displayed, no 1111 slot.
//  4 load asserted exactly on frame-wrap tick -> committed that tick, pending stays 0.
//  5 blank_in=4'b0010 -> digit1 slot seg=7'h7F dp=1 while an=4'b1101.
//  6 SEG7_BLINK_EN, blink_in=4'b0001 -> digit0 dark for 2 frames, lit 2 frames, repeating.

Source files
------------

// File: rtl/seg7_scan_if.sv
// Display-side bus for seg7_scan_driver: content load request, pending status and pin outputs.
// blink_in exists only when SEG7_BLINK_EN is defined.
interface seg7_scan_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   data_in;
  logic [DIGITS-1:0]     dp_in;
  logic [DIGITS-1:0]     blank_in;
`ifdef SEG7_BLINK_EN
  logic [DIGITS-1:0]     blink_in;
`endif
  logic                  pending;
  logic [6:0]            seg;
  logic                  dp;
  logic [DIGITS-1:0]     an;

  modport master (
`ifdef SEG7_BLINK_EN
    output blink_in,
`endif
    output load, data_in, dp_in, blank_in,
    input  pending, seg, dp, an
  );

  modport slave (
`ifdef SEG7_BLINK_EN
    input  blink_in,
`endif
    input  load, data_in, dp_in, blank_in,
    output pending, seg, dp, an
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment scanner with frame-synchronous shadow/display registers.
// Optional per-digit blinking is enabled by defining SEG7_BLINK_EN.
module seg7_scan_driver #(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned PRESCALE  = 50000,
  parameter int unsigned BLINK_DIV = 64
) (
  input logic        clk,
  input logic        reset,
  seg7_scan_if.slave bus
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [PW-1:0]         presc_q;
  logic [IW-1:0]         idx_q;
  logic [4*DIGITS-1:0]   sh_data_q, disp_data_q;
  logic [DIGITS-1:0]     sh_dp_q, disp_dp_q;
  logic [DIGITS-1:0]     sh_blank_q, disp_blank_q;
  logic                  pending_q;
  logic [6:0]            seg_q;
  logic                  dp_q;
  logic [DIGITS-1:0]     an_q;
`ifdef SEG7_BLINK_EN
  localparam int unsigned FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [DIGITS-1:0]     sh_blink_q, disp_blink_q;
  logic [FW-1:0]         frame_q;
  logic                  phase_q;  // 1 = blinking digits lit
`endif

  logic       tick;
  logic       wrap;
  logic       commit;
  logic       dark;
  logic [3:0] nib;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // idx_q names the digit driven in the slot that the next tick opens; the tick that opens the
  // last digit's slot is the frame boundary, so a commit there first shows on digit 0.
  always_comb begin
    tick   = (presc_q == PW'(PRESCALE - 1));
    wrap   = tick && (idx_q == IW'(DIGITS - 1));
    commit = wrap && (pending_q || bus.load);
    nib    = disp_data_q[{idx_q, 2'b00} +: 4];
    dark   = disp_blank_q[idx_q];
`ifdef SEG7_BLINK_EN
    dark   = dark | (disp_blink_q[idx_q] & ~phase_q);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q      <= '0;
      idx_q        <= '0;
      sh_data_q    <= '0;
      sh_dp_q      <= '0;
      sh_blank_q   <= '0;
      disp_data_q  <= '0;
      disp_dp_q    <= '0;
      disp_blank_q <= '1;
      pending_q    <= 1'b0;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      an_q         <= '1;
`ifdef SEG7_BLINK_EN
      sh_blink_q   <= '0;
      disp_blink_q <= '0;
      frame_q      <= '0;
      phase_q      <= 1'b1;
`endif
    end else begin
      presc_q <= tick ? '0 : presc_q + 1'b1;

      if (tick) begin
        idx_q <= wrap ? '0 : idx_q + 1'b1;
        an_q  <= ~(DIGITS'(1) << idx_q);
        seg_q <= dark ? 7'h7F : hex_to_seg(nib);
        dp_q  <= dark | ~disp_dp_q[idx_q];
      end

      if (bus.load) begin
        sh_data_q  <= bus.data_in;
        sh_dp_q    <= bus.dp_in;
        sh_blank_q <= bus.blank_in;
`ifdef SEG7_BLINK_EN
        sh_blink_q <= bus.blink_in;
`endif
      end

      // A load coinciding with the boundary bypasses the shadow so it is not a frame late.
      if (commit) begin
        disp_data_q  <= bus.load ? bus.data_in  : sh_data_q;
        disp_dp_q    <= bus.load ? bus.dp_in    : sh_dp_q;
        disp_blank_q <= bus.load ? bus.blank_in : sh_blank_q;
`ifdef SEG7_BLINK_EN
        disp_blink_q <= bus.load ? bus.blink_in : sh_blink_q;
`endif
        pending_q    <= 1'b0;
      end else if (bus.load) begin
        pending_q    <= 1'b1;
      end

`ifdef SEG7_BLINK_EN
      if (wrap) begin
        if (frame_q == FW'(BLINK_DIV - 1)) begin
          frame_q <= '0;
          phase_q <= ~phase_q;
        end else begin
          frame_q <= frame_q + 1'b1;
        end
      end
`endif
    end
  end

  assign bus.pending = pending_q;
  assign bus.seg     = seg_q;
  assign bus.dp      = dp_q;
  assign bus.an      = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a frame-level reference model predicts every digit slot.
// Blink stimulus and prediction are included when SEG7_BLINK_EN is defined.
module tb_seg7_scan_driver;

  localparam int unsigned DIGITS    = 4;
  localparam int unsigned PRESCALE  = 4;
  localparam int unsigned BLINK_DIV = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  seg7_scan_if #(.DIGITS(DIGITS)) bus ();

  seg7_scan_driver #(
    .DIGITS   (DIGITS),
    .PRESCALE (PRESCALE),
    .BLINK_DIV(BLINK_DIV)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [4*DIGITS-1:0] data;
    logic [DIGITS-1:0]   dp;
    logic [DIGITS-1:0]   blank;
    logic [DIGITS-1:0]   blink;
  } set_t;

  typedef struct {
    int                cyc;
    logic [DIGITS-1:0] an;
    logic [6:0]        seg;
    logic              dp;
  } slot_t;

  logic [6:0] seg_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100, 7'b0100000,
    7'b0001111, 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010,
    7'b0110000, 7'b0111000};

  slot_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  // Reference model state: cycles and slots since reset release, frames completed.
  int    m_cyc = 0;
  int    m_ticks = 0;
  int    m_wraps = 0;
  bit    m_pending = 0;
  set_t  m_sh;
  set_t  m_disp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic set_t sample_inputs();
    set_t s;
    s.data  = bus.data_in;
    s.dp    = bus.dp_in;
    s.blank = bus.blank_in;
`ifdef SEG7_BLINK_EN
    s.blink = bus.blink_in;
`else
    s.blink = '0;
`endif
    return s;
  endfunction

  // Model: slot k of the run shows digit k mod DIGITS; content changes only between frames.
  always @(posedge clk) begin
    set_t  cur;
    slot_t e;
    int    d;
    bit    dark;
    bit    is_wrap;
    if (reset) begin
      m_cyc = 0;
      m_ticks = 0;
      m_wraps = 0;
      m_pending = 0;
      m_sh = '{data: '0, dp: '0, blank: '0, blink: '0};
      m_disp = '{data: '0, dp: '0, blank: '1, blink: '0};
      exp_q.delete();
    end else begin
      cur = sample_inputs();
      is_wrap = 0;
      if (m_cyc % PRESCALE == PRESCALE - 1) begin
        d = m_ticks % DIGITS;
        dark = m_disp.blank[d] | (m_disp.blink[d] & ((m_wraps / BLINK_DIV) % 2 == 1));
        e.cyc = m_cyc + 1;
        e.an  = ~(DIGITS'(1) << d);
        e.seg = dark ? 7'h7F : seg_tab[m_disp.data[4*d +: 4]];
        e.dp  = dark | ~m_disp.dp[d];
        exp_q.push_back(e);
        m_ticks++;
        is_wrap = (d == DIGITS - 1);
      end
      if (bus.load) m_sh = cur;
      if (is_wrap) begin
        m_wraps++;
        if (m_pending || bus.load) m_disp = m_sh;
        m_pending = 0;
      end else if (bus.load) begin
        m_pending = 1;
      end
      m_cyc++;
    end
  end

  logic [DIGITS-1:0] prev_an = '1;

  always @(negedge clk) begin
    slot_t e;
    if (reset) begin
      prev_an = '1;
    end else begin
      if (bus.an !== prev_an && bus.an !== '1) begin
        if (exp_q.size() == 0) begin
          check("slot_unexpected", {bus.an, bus.seg, bus.dp}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("slot_time", m_cyc, e.cyc);
          check("slot_out", {bus.an, bus.seg, bus.dp}, {e.an, e.seg, e.dp});
        end
      end
      prev_an = bus.an;
      check("pending", bus.pending, m_pending);
    end
  end

  task automatic drive(input set_t s);
    bus.data_in  = s.data;
    bus.dp_in    = s.dp;
    bus.blank_in = s.blank;
`ifdef SEG7_BLINK_EN
    bus.blink_in = s.blink;
`endif
  endtask

  // Called at a negedge; load is seen by exactly one posedge.
  task automatic pulse(input set_t s);
    drive(s);
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_seg"}, bus.seg, 7'h7F);
    check({tag, "_dp"}, bus.dp, 1'b1);
    check({tag, "_an"}, bus.an, {DIGITS{1'b1}});
    check({tag, "_pending"}, bus.pending, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_reset_outputs("rst_async");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    repeat (n * DIGITS * PRESCALE) @(negedge clk);
  endtask

  initial begin
    set_t s;
    bit   found;
    bus.load = 1'b0;
    drive('{data: '0, dp: '0, blank: '0, blink: '0});
    repeat (3) @(negedge clk);
    check_reset_outputs("rst_init");
    reset = 1'b0;
    wait_frames(2);

    // Directed content with a decimal point on digit 2.
    pulse('{data: 16'h8A31, dp: 4'b0100, blank: 4'b0000, blink: 4'b0000});
    check("pending_after_load", bus.pending, 1'b1);
    wait_frames(3);

    // Two loads inside one frame: only the second may reach the display.
    found = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (m_cyc % PRESCALE == 0 && m_ticks % DIGITS == 1) begin
        found = 1;
        break;
      end
    end
    check("wait_midframe", found, 1'b1);
    pulse('{data: 16'h1111, dp: 4'b0000, blank: 4'b0000, blink: 4'b0000});
    @(negedge clk);
    pulse('{data: 16'h2222, dp: 4'b1000, blank: 4'b0000, blink: 4'b0000});
    wait_frames(2);

    // Load landing exactly on the frame-boundary tick.
    found = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (m_cyc % PRESCALE == PRESCALE - 1 && m_ticks % DIGITS == DIGITS - 1) begin
        found = 1;
        break;
      end
    end
    check("wait_wrap", found, 1'b1);
    pulse('{data: 16'hC0DE, dp: 4'b0001, blank: 4'b0000, blink: 4'b0000});
    check("load_on_wrap_pending", bus.pending, 1'b0);
    wait_frames(2);

    // Blanked digit keeps its strobe.
    pulse('{data: 16'h4567, dp: 4'b0010, blank: 4'b0010, blink: 4'b0000});
    wait_frames(3);

`ifdef SEG7_BLINK_EN
    pulse('{data: 16'h9BEF, dp: 4'b0001, blank: 4'b0000, blink: 4'b0001});
    wait_frames(9);
`endif

    // Randomized loads, with the occasional long quiet gap.
    for (int i = 0; i < 250; i++) begin
      repeat ($urandom_range(0, ($urandom_range(0, 3) == 0) ? 40 : 10)) @(negedge clk);
      s.data  = 16'($urandom);
      s.dp    = 4'($urandom);
      s.blank = 4'($urandom & $urandom);
      s.blink = 4'($urandom);
      pulse(s);
    end
    wait_frames(1);

    // Reset in the middle of a scan, with a load still pending.
    repeat (5) @(negedge clk);
    pulse('{data: 16'h7777, dp: 4'b1111, blank: 4'b0000, blink: 4'b0000});
    do_reset();
    wait_frames(3);
    pulse('{data: 16'h0F5D, dp: 4'b0000, blank: 4'b1000, blink: 4'b0000});
    wait_frames(3);

    @(negedge clk);
    #1 check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
